spi_nor_shifter: RTL and testbench
==================================

// Module: spi_nor_shifter
// PURPOSE
//  Bit-serial SPI engine directly downstream of the APB-to-SPI-NOR controller.
//  Accepts one word-level command (opcode + 24-bit address + 32-bit data), frames it
//  as a 64-bit MSB-first SPI transaction, and returns the 32 data bits read from MISO.
//  Owns all pin timing: s_clk generation, s_css framing, MOSI drive and MISO sampling.
// PARAMETERS
//  CLK_DIV   2   p_clk cycles per s_clk half-period; legal range >= 1
//  CPOL      0   s_clk idle level; CPHA is tied to CPOL, so only modes 0 and 3 exist
//  LINEWIDE  32  data word width; the frame is 8 + 24 + LINEWIDE bits
// PORTS
//  p_clk      in   1   system clock; all logic on its rising edge
//  p_rst      in   1   synchronous, active-high reset
//  cmd_valid  in   1   command offered
//  cmd_ready  out  1   command accepted when cmd_valid && cmd_ready
//  cmd_write  in   1   1 = write (opcode 8'h02), 0 = read (opcode 8'h03)
//  cmd_addr   in   24  flash byte address, sent MSB first
//  cmd_wdata  in   32  write data; ignored on reads
//  rsp_valid  out  1   one-cycle pulse at transaction end
//  rsp_rdata  out  32  read data; 0 for writes; held until the next rsp_valid
//  busy       out  1   high from acceptance until the rsp_valid cycle, exclusive
//  s_clk      out  1   SPI clock
//  s_css      out  1   chip select, active low
//  s_mosi     out  1   serial data out
//  s_miso     in   1   serial data in
// BEHAVIOUR
//  Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, s_clk=CPOL, s_css=1, s_mosi=0.
//  - cmd_ready = (state==IDLE). Inputs are captured into a 64-bit shift register on the
//    accept cycle T: {opcode, addr, write ? wdata : 32'h0}.
//  FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
//  - SETUP, T+1 .. T+CLK_DIV: s_css=0, s_clk=CPOL, s_mosi=frame bit 63.
//  - SHIFT, 128*CLK_DIV cycles: s_clk toggles at each divider terminal count (128 toggles).
//    - On the p_clk edge where s_clk goes 0->1, shift s_miso into the read register LSB.
//    - On each 1->0 toggle that follows at least one sample, present the next frame bit
//      on s_mosi. In mode 3 the first falling toggle does not shift.
//    - At SHIFT exit, s_clk==CPOL.
//  - HOLD, CLK_DIV cycles: s_css=0, s_clk=CPOL.
//  - IDLE entry at T+130*CLK_DIV+1: s_css=1, s_mosi=0, rsp_valid=1 for one cycle,
//    rsp_rdata = last 32 sampled bits (MSB first) for reads, 0 for writes.
//  Boundary cases:
//  - cmd_valid while busy: ignored. No queuing; the command must be held until cmd_ready.
//  - Back-to-back: a command may be accepted in the rsp_valid cycle. s_css is then
//    high for exactly one p_clk cycle between frames.
//  - p_rst mid-transaction: the next cycle shows reset values. No rsp_valid. The frame
//    is abandoned, and the slave sees s_css rise.
//  - Divider: counter width $clog2(CLK_DIV+1). It resets to 0 on every state entry
//    and wraps at CLK_DIV-1. The bit counter is 7 bits and counts 128 toggles exactly.
// STRUCTURE
//  - spi_nor_pkg holds: OP_READ=8'h03, OP_WRITE=8'h02, FRAME_BITS=64, state encoding
//    (IDLE=2'd0, SETUP=2'd1, SHIFT=2'd2, HOLD=2'd3).
//  - Sub-module spi_clk_gen: half-period divider plus the s_clk register. It emits
//    rise_stb/fall_stb one-cycle strobes and is enabled only in SHIFT.
//  - The top level keeps the FSM, the frame shift register and the read register.
// TESTING
//  1. Mode 0, CLK_DIV=2, write addr 24'h123456, wdata 32'hDEADBEEF, accepted at T
//     -> MOSI sampled on rising edges = 64'h02123456DEADBEEF; 64 rising edges;
//     rsp_valid at T+261; rsp_rdata=0.
//  2. Mode 0, CLK_DIV=2, read addr 24'h000100; MISO model drives 32'hCAFEF00D after
//     the 32nd bit -> MOSI carries 32'h03000100; rsp_rdata=32'hCAFEF00D.
//  3. Mode 3 (CPOL=1), CLK_DIV=1, repeat the read of test 2 -> same data;
//     s_clk idles high before and after; rsp_valid at T+131.
//  4. Assert p_rst for one cycle after the 20th rising edge -> next cycle s_css=1,
//     s_clk=CPOL, busy=0; no rsp_valid; a following command completes normally.
//  5. Hold cmd_valid high across two commands -> cmd_ready=0 throughout the first;
//     the second is accepted in the rsp_valid cycle; s_css high for exactly 1 cycle.
//  6. cmd_valid pulsed for one cycle while busy -> no effect on the frame or on
//     rsp_rdata; no extra transaction.

Source files
------------

// File: rtl/spi_nor_pkg.sv
// Shared constants and state encoding for the SPI-NOR bit-serial shifter.
package spi_nor_pkg;

  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam int         FRAME_BITS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Flash opcode for a command direction.
  function automatic logic [7:0] opcode_for(input logic write);
    return write ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider and s_clk register. The divider free-runs outside IDLE so
// the FSM can time SETUP and HOLD with it; s_clk only toggles while en is high.
module spi_clk_gen #(
  parameter int   CLK_DIV = 2,
  parameter logic CPOL    = 1'b0
) (
  input  logic p_clk,
  input  logic p_rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic rise_stb,
  output logic fall_stb,
  output logic s_clk
);

  localparam int               CNT_W    = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  assign tc       = (div_cnt == CNT_LAST);
  assign rise_stb = en && tc && !s_clk;
  assign fall_stb = en && tc &&  s_clk;

  // Divider: held at zero in IDLE, wraps at terminal count so every state starts at zero.
  always_ff @(posedge p_clk) begin
    if (p_rst || clr) begin
      div_cnt <= '0;
    end else if (tc) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // SPI clock: parked at CPOL, toggles on each terminal count while enabled.
  always_ff @(posedge p_clk) begin
    if (p_rst || clr) begin
      s_clk <= CPOL;
    end else if (en && tc) begin
      s_clk <= ~s_clk;
    end
  end

endmodule

// File: rtl/spi_nor_shifter.sv
// Bit-serial SPI-NOR engine: frames one opcode/address/data command as an
// MSB-first transaction, drives the pins and returns the sampled read word.
module spi_nor_shifter
  import spi_nor_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter logic CPOL     = 1'b0,
  parameter int   LINEWIDE = 32
) (
  input  logic                p_clk,
  input  logic                p_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [23:0]         cmd_addr,
  input  logic [LINEWIDE-1:0] cmd_wdata,
  output logic                rsp_valid,
  output logic [LINEWIDE-1:0] rsp_rdata,
  output logic                busy,
  output logic                s_clk,
  output logic                s_css,
  output logic                s_mosi,
  input  logic                s_miso
);

  localparam int               FRAME_W  = 8 + 24 + LINEWIDE;
  localparam int               TOGGLES  = 2 * FRAME_W;
  localparam int               TOG_W    = $clog2(TOGGLES);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(TOGGLES - 1);

  state_t              state;
  logic [FRAME_W-1:0]  frame_sr;
  logic [FRAME_W-1:0]  frame_ld;
  logic [LINEWIDE-1:0] rd_sr;
  logic [TOG_W-1:0]    tog_cnt;
  logic                is_write;
  logic                seen_rise;
  logic                accept;
  logic                shift_out;
  logic                tc;
  logic                rise_stb;
  logic                fall_stb;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign frame_ld  = {opcode_for(cmd_write), cmd_addr, cmd_wdata & {LINEWIDE{cmd_write}}};
  // Mode 3 opens with a falling toggle before any sample; that one must not shift.
  assign shift_out = fall_stb && seen_rise;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .p_clk    (p_clk),
    .p_rst    (p_rst),
    .clr      (state == IDLE),
    .en       (state == SHIFT),
    .tc       (tc),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .s_clk    (s_clk)
  );

  // Transaction FSM with registered pin and response outputs.
  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      state     <= IDLE;
      s_css     <= 1'b1;
      s_mosi    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      tog_cnt   <= '0;
      is_write  <= 1'b0;
      seen_rise <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SETUP;
            s_css     <= 1'b0;
            s_mosi    <= frame_ld[FRAME_W-1];
            is_write  <= cmd_write;
            tog_cnt   <= '0;
            seen_rise <= 1'b0;
          end
        end
        SETUP: begin
          if (tc) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise_stb) begin
            seen_rise <= 1'b1;
          end
          if (shift_out) begin
            s_mosi <= frame_sr[FRAME_W-2];
          end
          if (rise_stb || fall_stb) begin
            tog_cnt <= tog_cnt + TOG_W'(1);
            if (tog_cnt == TOG_LAST) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (tc) begin
            state     <= IDLE;
            s_css     <= 1'b1;
            s_mosi    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= is_write ? '0 : rd_sr;
          end
        end
      endcase
    end
  end

  // Frame and read shift registers: load on accept, move on the s_clk strobes.
  always_ff @(posedge p_clk) begin
    if (accept) begin
      frame_sr <= frame_ld;
    end else if (shift_out) begin
      frame_sr <= {frame_sr[FRAME_W-2:0], 1'b0};
    end
    if (rise_stb) begin
      rd_sr <= {rd_sr[LINEWIDE-2:0], s_miso};
    end
  end

endmodule

// File: tb/tb_spi_nor_shifter.sv
// Bench for spi_nor_shifter: a mode-0/CLK_DIV=2 and a mode-3/CLK_DIV=1 instance
// driven by directed and random commands, checked against a frame-level model.
`timescale 1ns/1ps
module tb_spi_nor_shifter;
  import spi_nor_pkg::*;

  logic p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  logic [1:0]  p_rst     = 2'b11;
  logic [1:0]  cmd_valid = 2'b00;
  logic [1:0]  cmd_write = 2'b00;
  logic [23:0] cmd_addr  [2];
  logic [31:0] cmd_wdata [2];
  logic [1:0]  s_miso    = 2'b00;
  wire  [1:0]  cmd_ready, rsp_valid, busy, s_clk, s_css, s_mosi;
  wire  [31:0] rsp_rdata [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Slave-side observation, updated only by the monitor process.
  int          rises      [2] = '{0, 0};
  logic [63:0] mosi_frame [2] = '{64'h0, 64'h0};
  int          hi_run     [2] = '{0, 0};
  int          last_gap   [2] = '{0, 0};
  int          frames     [2] = '{0, 0};
  int          rsp_cnt    [2] = '{0, 0};
  logic [1:0]  css_q = 2'b11;
  logic [1:0]  clk_q = 2'b10;
  logic [31:0] miso_word  [2];

  spi_nor_shifter #(.CLK_DIV(2), .CPOL(1'b0), .LINEWIDE(32)) u_dut_m0 (
    .p_clk(p_clk), .p_rst(p_rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .s_clk(s_clk[0]), .s_css(s_css[0]), .s_mosi(s_mosi[0]), .s_miso(s_miso[0]));

  spi_nor_shifter #(.CLK_DIV(1), .CPOL(1'b1), .LINEWIDE(32)) u_dut_m3 (
    .p_clk(p_clk), .p_rst(p_rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .s_clk(s_clk[1]), .s_css(s_css[1]), .s_mosi(s_mosi[1]), .s_miso(s_miso[1]));

  always @(posedge p_clk) cyc <= cyc + 1;

  // SPI slave model: captures MOSI on s_clk rises, serves junk for the first 32
  // bits and miso_word MSB first for the last 32, changing MISO after each rise.
  always @(negedge p_clk) begin
    for (int g = 0; g < 2; g++) begin
      if (css_q[g] && !s_css[g]) begin
        rises[g]      <= 0;
        mosi_frame[g] <= 64'h0;
        frames[g]     <= frames[g] + 1;
        last_gap[g]   <= hi_run[g];
        s_miso[g]     <= 1'($urandom);
      end else if (!s_css[g] && !clk_q[g] && s_clk[g]) begin
        rises[g]      <= rises[g] + 1;
        mosi_frame[g] <= {mosi_frame[g][62:0], s_mosi[g]};
        if (rises[g] >= 31 && rises[g] < 63) s_miso[g] <= miso_word[g][62 - rises[g]];
        else                                 s_miso[g] <= 1'($urandom);
      end
      hi_run[g] <= s_css[g] ? hi_run[g] + 1 : 0;
      if (rsp_valid[g]) rsp_cnt[g] <= rsp_cnt[g] + 1;
    end
    css_q <= s_css;
    clk_q <= s_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int cdiv(input int m);
    return (m == 0) ? 2 : 1;
  endfunction

  function automatic logic cpol(input int m);
    return (m == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [63:0] exp_frame(input logic w, input logic [23:0] a, input logic [31:0] d);
    return {(w ? 8'h02 : 8'h03), a, (w ? d : 32'h0)};
  endfunction

  // Offer a command, wait for acceptance, then drop valid and scramble the fields.
  task automatic start_cmd(input int m, input logic w, input logic [23:0] a,
                           input logic [31:0] d, input logic [31:0] mw, output int t_acc);
    int guard = 0;
    miso_word[m]    = mw;
    cmd_write[m]    = w;
    cmd_addr[m]     = a;
    cmd_wdata[m]    = d;
    cmd_valid[m]    = 1'b1;
    while (cmd_ready[m] !== 1'b1 && guard < 1000) begin
      @(negedge p_clk);
      guard++;
    end
    chk("accept_wait", 64'(guard < 1000), 64'h1);
    t_acc = cyc;
    @(negedge p_clk);
    cmd_valid[m] = 1'b0;
    cmd_write[m] = 1'($urandom);
    cmd_addr[m]  = 24'($urandom);
    cmd_wdata[m] = $urandom;
  endtask

  // Follow a frame to its response and compare everything against the model.
  task automatic finish_cmd(input int m, input int t_acc, input logic w, input logic [23:0] a,
                            input logic [31:0] d, input logic [31:0] mw, input string tag,
                            output int t_rsp);
    int guard = 0;
    bit busy_ok = 1'b1, rdy_ok = 1'b1, css_ok = 1'b1;
    logic [31:0] exp_rd;
    exp_rd = w ? 32'h0 : mw;
    while (rsp_valid[m] !== 1'b1 && guard < 400) begin
      if (busy[m] !== 1'b1)      busy_ok = 1'b0;
      if (cmd_ready[m] !== 1'b0) rdy_ok  = 1'b0;
      if (s_css[m] !== 1'b0)     css_ok  = 1'b0;
      @(negedge p_clk);
      guard++;
    end
    t_rsp = cyc;
    chk({tag, "_rsp_wait"}, 64'(guard < 400), 64'h1);
    chk({tag, "_busy_high"}, 64'(busy_ok), 64'h1);
    chk({tag, "_ready_low"}, 64'(rdy_ok), 64'h1);
    chk({tag, "_css_low"}, 64'(css_ok), 64'h1);
    chk({tag, "_latency"}, 64'(t_rsp - t_acc), 64'(130 * cdiv(m) + 1));
    chk({tag, "_rdata"}, 64'(rsp_rdata[m]), 64'(exp_rd));
    chk({tag, "_mosi_frame"}, mosi_frame[m], exp_frame(w, a, d));
    chk({tag, "_rises"}, 64'(rises[m]), 64'(FRAME_BITS));
    chk({tag, "_end_pins"}, 64'({busy[m], s_css[m], s_mosi[m], s_clk[m]}), 64'({3'b010, cpol(m)}));
    @(negedge p_clk);
    chk({tag, "_pulse"}, 64'(rsp_valid[m]), 64'h0);
    chk({tag, "_rdata_held"}, 64'(rsp_rdata[m]), 64'(exp_rd));
  endtask

  initial begin
    int t0, t1, cnt, fr, guard;
    logic w;
    logic [23:0] a;
    logic [31:0] d, mw;
    for (int m = 0; m < 2; m++) begin
      cmd_addr[m]  = '0;
      cmd_wdata[m] = '0;
      miso_word[m] = '0;
    end

    // Reset values
    repeat (3) @(negedge p_clk);
    for (int m = 0; m < 2; m++) begin
      chk("rst_ready", 64'(cmd_ready[m]), 64'h1);
      chk("rst_rsp", 64'({rsp_valid[m], busy[m]}), 64'h0);
      chk("rst_rdata", 64'(rsp_rdata[m]), 64'h0);
      chk("rst_pins", 64'({s_clk[m], s_css[m], s_mosi[m]}), 64'({cpol(m), 2'b10}));
    end
    p_rst = 2'b00;
    @(negedge p_clk);

    // Mode 0 write
    start_cmd(0, 1'b1, 24'h123456, 32'hDEADBEEF, 32'h0, t0);
    finish_cmd(0, t0, 1'b1, 24'h123456, 32'hDEADBEEF, 32'h0, "wr_m0", t1);

    // Mode 0 read
    start_cmd(0, 1'b0, 24'h000100, 32'h5555AAAA, 32'hCAFEF00D, t0);
    finish_cmd(0, t0, 1'b0, 24'h000100, 32'h5555AAAA, 32'hCAFEF00D, "rd_m0", t1);

    // Reset after the 20th rising edge abandons the frame
    start_cmd(0, 1'b0, 24'hABCDEF, 32'h0, 32'h12345678, t0);
    guard = 0;
    while (rises[0] < 20 && guard < 400) begin
      @(negedge p_clk);
      guard++;
    end
    chk("abort_rise_wait", 64'(guard < 400), 64'h1);
    p_rst[0] = 1'b1;
    @(negedge p_clk);
    chk("abort_pins", 64'({s_css[0], s_clk[0], s_mosi[0]}), 64'b100);
    chk("abort_ctrl", 64'({busy[0], cmd_ready[0], rsp_valid[0]}), 64'b010);
    chk("abort_rdata", 64'(rsp_rdata[0]), 64'h0);
    p_rst[0] = 1'b0;
    cnt = rsp_cnt[0];
    repeat (300) @(negedge p_clk);
    chk("abort_no_rsp", 64'(rsp_cnt[0]), 64'(cnt));
    chk("abort_css_idle", 64'(s_css[0]), 64'h1);
    start_cmd(0, 1'b0, 24'h000100, 32'h0, 32'h0F1E2D3C, t0);
    finish_cmd(0, t0, 1'b0, 24'h000100, 32'h0, 32'h0F1E2D3C, "post_abort", t1);

    // Mode 3 read with CLK_DIV=1
    chk("m3_clk_idle_high", 64'(s_clk[1]), 64'h1);
    start_cmd(1, 1'b0, 24'h000100, 32'h0, 32'hCAFEF00D, t0);
    finish_cmd(1, t0, 1'b0, 24'h000100, 32'h0, 32'hCAFEF00D, "rd_m3", t1);

    // cmd_valid held across two commands: second accepted in the response cycle
    cmd_write[0] = 1'b1;
    cmd_addr[0]  = 24'h00FF00;
    cmd_wdata[0] = 32'h01234567;
    cmd_valid[0] = 1'b1;
    chk("b2b_ready_before", 64'(cmd_ready[0]), 64'h1);
    t0 = cyc;
    @(negedge p_clk);
    cmd_write[0] = 1'b0;
    cmd_addr[0]  = 24'hFEDCBA;
    cmd_wdata[0] = 32'h89ABCDEF;
    miso_word[0] = 32'hA5C3_0FF0;
    finish_cmd(0, t0, 1'b1, 24'h00FF00, 32'h01234567, 32'h0, "b2b_first", t1);
    cmd_valid[0] = 1'b0;
    chk("b2b_second_busy", 64'(busy[0]), 64'h1);
    finish_cmd(0, t1, 1'b0, 24'hFEDCBA, 32'h89ABCDEF, 32'hA5C3_0FF0, "b2b_second", t0);
    chk("b2b_css_gap", 64'(last_gap[0]), 64'h1);

    // cmd_valid pulsed mid-frame is ignored
    cnt = rsp_cnt[0];
    fr  = frames[0];
    start_cmd(0, 1'b1, 24'h0A0B0C, 32'hFACE0FF1, 32'h0, t0);
    repeat (60) @(negedge p_clk);
    cmd_write[0] = 1'b0;
    cmd_addr[0]  = 24'h777777;
    cmd_valid[0] = 1'b1;
    @(negedge p_clk);
    cmd_valid[0] = 1'b0;
    finish_cmd(0, t0, 1'b1, 24'h0A0B0C, 32'hFACE0FF1, 32'h0, "busy_pulse", t1);
    repeat (40) @(negedge p_clk);
    chk("busy_pulse_frames", 64'(frames[0]), 64'(fr + 1));
    chk("busy_pulse_rsps", 64'(rsp_cnt[0]), 64'(cnt + 1));
    chk("busy_pulse_idle", 64'({s_css[0], cmd_ready[0]}), 64'b11);

    // Random commands on both instances
    for (int i = 0; i < 12; i++) begin
      int m;
      m  = i % 2;
      w  = 1'($urandom);
      a  = 24'($urandom);
      d  = $urandom;
      mw = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge p_clk);
      start_cmd(m, w, a, d, mw, t0);
      finish_cmd(m, t0, w, a, d, mw, (m == 0) ? "rand_m0" : "rand_m3", t1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
